// File: rtl/alu_inverse.sv
// alu_inverse
// -----------------------------------------------------------------------------
// Sequential inverse-operation unit companion to the accumulator ALU. It undoes
// add / multiply / shift with subtract / divide / logical right shift, plus a
// hold operation. Subtract, shift, hold and divide-by-zero finish in one cycle.
// A regular divide runs an 8-iteration restoring divider.
//
// Handshake: a request is accepted on a rising Clock edge where Start = 1 and
// the unit is IDLE (Busy = 0). Start while Busy is ignored and not queued.
// Completion is signalled by Done, a one-cycle pulse during which Result,
// Remainder and DivByZero carry the new values; those outputs then hold until
// the next accepted request.
//
// Ports
//   Clock      in   1  rising-edge clock
//   Reset_b    in   1  asynchronous active-low reset
//   Start      in   1  request, sampled only in IDLE
//   Function   in   2  0 subtract, 1 divide, 2 logical right shift, 3 hold
//   Operand    in   8  dividend / minuend / shift source
//   Data       in   4  divisor / subtrahend / shift amount
//   Result     out  8  registered result
//   Remainder  out  4  registered division remainder (0 for other functions)
//   Busy       out  1  high whenever the FSM is not IDLE
//   Done       out  1  one-cycle completion pulse
//   DivByZero  out  1  set by a divide with Data == 0
//   state_dbg  out  2  current FSM state encoding (0 IDLE, 1 DIV, 2 DONE)
// -----------------------------------------------------------------------------
module alu_inverse (
  input  logic       Clock,
  input  logic       Reset_b,
  input  logic       Start,
  input  logic [1:0] Function,
  input  logic [7:0] Operand,
  input  logic [3:0] Data,
  output logic [7:0] Result,
  output logic [3:0] Remainder,
  output logic       Busy,
  output logic       Done,
  output logic       DivByZero,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] FN_SUB   = 2'd0;
  localparam logic [1:0] FN_DIV   = 2'd1;
  localparam logic [1:0] FN_SHR   = 2'd2;
  localparam logic [1:0] FN_HOLD  = 2'd3;

  state_t      state_q,     state_d;
  logic [7:0]  quot_q,      quot_d;      // quotient / dividend shift register
  logic [4:0]  prem_q,      prem_d;      // 5-bit partial remainder
  logic [3:0]  cnt_q,       cnt_d;       // iterations left
  logic [3:0]  divisor_q,   divisor_d;   // divisor latched at Start
  logic [7:0]  result_q,    result_d;
  logic [3:0]  remainder_q, remainder_d;
  logic        dbz_q,       dbz_d;

  // One restoring-division step, computed from the registered state.
  logic [4:0]  div_p;
  logic [7:0]  div_quot;
  logic [4:0]  div_prem;

  always_comb begin
    div_p    = {prem_q[3:0], quot_q[7]};
    div_quot = {quot_q[6:0], 1'b0};
    div_prem = div_p;
    if (div_p >= {1'b0, divisor_q}) begin
      div_prem    = div_p - {1'b0, divisor_q};
      div_quot[0] = 1'b1;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    quot_d      = quot_q;
    prem_d      = prem_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          dbz_d     = 1'b0;
          divisor_d = Data;
          case (Function)
            FN_SUB: begin
              // 8-bit wrap, no borrow output.
              result_d    = Operand - {4'b0000, Data};
              remainder_d = 4'h0;
              state_d     = S_DONE;
            end
            FN_DIV: begin
              if (Data == 4'h0) begin
                result_d    = 8'hFF;
                remainder_d = 4'hF;
                dbz_d       = 1'b1;
                state_d     = S_DONE;
              end else begin
                quot_d  = Operand;
                prem_d  = 5'd0;
                cnt_d   = 4'd8;
                state_d = S_DIV;
              end
            end
            FN_SHR: begin
              // Shift amounts of 8..15 clear the whole byte.
              result_d    = Data[3] ? 8'h00 : (Operand >> Data[2:0]);
              remainder_d = 4'h0;
              state_d     = S_DONE;
            end
            FN_HOLD: begin
              remainder_d = 4'h0;
              state_d     = S_DONE;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end

      S_DIV: begin
        quot_d = div_quot;
        prem_d = div_prem;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          // Remainder is always below the divisor, so 4 bits suffice.
          result_d    = div_quot;
          remainder_d = div_prem[3:0];
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q     <= S_IDLE;
      quot_q      <= 8'h00;
      prem_q      <= 5'd0;
      cnt_q       <= 4'd0;
      divisor_q   <= 4'h0;
      result_q    <= 8'h00;
      remainder_q <= 4'h0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      quot_q      <= quot_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign Result    = result_q;
  assign Remainder = remainder_q;
  assign DivByZero = dbz_q;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_inverse.sv
// Testbench for alu_inverse: directed cases followed by random operations.
// Expected results are computed by a small behavioural model and queued when
// a request is driven; the monitor pops and compares on every Done pulse.
module tb_alu_inverse;

  logic       Clock;
  logic       Reset_b;
  logic       Start;
  logic [1:0] Function;
  logic [7:0] Operand;
  logic [3:0] Data;
  logic [7:0] Result;
  logic [3:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       DivByZero;
  logic [1:0] state_dbg;

  alu_inverse dut (
    .Clock     (Clock),
    .Reset_b   (Reset_b),
    .Start     (Start),
    .Function  (Function),
    .Operand   (Operand),
    .Data      (Data),
    .Result    (Result),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- scoreboard ----------------
  localparam int W = 13;  // {result[7:0], remainder[3:0], div_by_zero}
  logic [W-1:0] exp_q[$];
  logic [7:0]   model_result;
  int           n_checks;
  int           n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference for one accepted request.
  task automatic push_expected(input logic [1:0] f, input logic [7:0] a, input logic [3:0] d);
    logic [7:0] r;
    logic [3:0] rm;
    logic       z;
    r  = model_result;
    rm = 4'h0;
    z  = 1'b0;
    case (f)
      2'd0: r = a - 8'(d);
      2'd1: begin
        if (d == 4'h0) begin
          r  = 8'hFF;
          rm = 4'hF;
          z  = 1'b1;
        end else begin
          r  = 8'(int'(a) / int'(d));
          rm = 4'(int'(a) % int'(d));
        end
      end
      2'd2: r = (d >= 4'd8) ? 8'h00 : 8'(int'(a) >> int'(d));
      default: r = model_result;
    endcase
    model_result = r;
    exp_q.push_back({r, rm, z});
  endtask

  // Monitor: compare on every Done pulse.
  always @(negedge Clock) begin
    if (Reset_b && Done) begin
      check_eq("done_has_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check_eq("result",    32'(Result),    32'(e[12:5]));
        check_eq("remainder", 32'(Remainder), 32'(e[4:1]));
        check_eq("divbyzero", 32'(DivByZero), 32'(e[0]));
      end
    end
  end

  // ---------------- driver ----------------
  // Drives one request and waits for Done. inject_at > 0 re-pulses Start (a
  // subtract) that many cycles after acceptance; it must be ignored.
  task automatic run_op(input logic [1:0] f, input logic [7:0] a, input logic [3:0] d,
                        input int exp_lat, input int inject_at);
    int cycles;
    @(negedge Clock);
    Start    = 1'b1;
    Function = f;
    Operand  = a;
    Data     = d;
    push_expected(f, a, d);
    @(negedge Clock);
    Start  = 1'b0;
    cycles = 1;
    check_eq("busy_after_start", 32'(Busy), 32'd1);
    while (!Done && cycles < 40) begin
      if (cycles == inject_at) begin
        Start    = 1'b1;
        Function = 2'd0;
        Operand  = 8'($urandom_range(0, 255));
        Data     = 4'd3;
      end
      @(negedge Clock);
      Start    = 1'b0;
      Function = 2'($urandom_range(0, 3));
      Operand  = 8'($urandom_range(0, 255));
      Data     = 4'($urandom_range(0, 15));
      cycles++;
    end
    check_eq("latency", 32'(cycles), 32'(exp_lat));
    check_eq("busy_in_done", 32'(Busy), 32'd1);
    @(negedge Clock);
    check_eq("done_pulse_len", 32'(Done), 32'd0);
    check_eq("idle_after", 32'(Busy), 32'd0);
    check_eq("result_hold", 32'(Result), 32'(model_result));
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    model_result = 8'h00;
    Reset_b      = 1'b0;
    Start        = 1'b0;
    Function     = 2'd0;
    Operand      = 8'h00;
    Data         = 4'h0;
    repeat (2) @(negedge Clock);
    check_eq("rst_result",    32'(Result),    32'd0);
    check_eq("rst_remainder", 32'(Remainder), 32'd0);
    check_eq("rst_busy",      32'(Busy),      32'd0);
    check_eq("rst_done",      32'(Done),      32'd0);
    check_eq("rst_dbz",       32'(DivByZero), 32'd0);
    check_eq("rst_state",     32'(state_dbg), 32'd0);
    Reset_b = 1'b1;

    // Subtract, including wrap.
    run_op(2'd0, 8'h10, 4'd3, 1, 0);
    run_op(2'd0, 8'h02, 4'd5, 1, 0);
    // Divide and divide-by-zero, then a subtract clears the flag.
    run_op(2'd1, 8'd200, 4'd7, 9, 0);
    run_op(2'd1, 8'h55, 4'd0, 1, 0);
    run_op(2'd0, 8'h20, 4'd1, 1, 0);
    // Shifts, oversize shift, hold.
    run_op(2'd2, 8'hB4, 4'd2, 1, 0);
    run_op(2'd2, 8'hB4, 4'd9, 1, 0);
    run_op(2'd3, 8'hAA, 4'd1, 1, 0);
    // Start while busy is ignored.
    run_op(2'd1, 8'd255, 4'd15, 9, 2);
    // Extreme divides.
    run_op(2'd1, 8'd255, 4'd1, 9, 0);
    run_op(2'd1, 8'd0, 4'd9, 9, 0);

    // Reset in the middle of a divide: aborted, nothing queued for it.
    @(negedge Clock);
    Start    = 1'b1;
    Function = 2'd1;
    Operand  = 8'd255;
    Data     = 4'd15;
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    #2 Reset_b = 1'b0;
    #1;
    check_eq("mid_rst_result",    32'(Result),    32'd0);
    check_eq("mid_rst_remainder", 32'(Remainder), 32'd0);
    check_eq("mid_rst_busy",      32'(Busy),      32'd0);
    check_eq("mid_rst_done",      32'(Done),      32'd0);
    check_eq("mid_rst_dbz",       32'(DivByZero), 32'd0);
    repeat (2) @(negedge Clock);
    Reset_b      = 1'b1;
    model_result = 8'h00;
    repeat (10) @(negedge Clock);
    check_eq("no_done_after_abort", 32'(exp_q.size()), 32'd0);
    check_eq("idle_after_abort",    32'(Busy),         32'd0);
    run_op(2'd0, 8'h40, 4'd4, 1, 0);

    // Random operations.
    for (int i = 0; i < 30; i++) begin
      logic [1:0] f;
      logic [7:0] a;
      logic [3:0] d;
      f = 2'($urandom_range(0, 3));
      a = 8'($urandom_range(0, 255));
      d = 4'($urandom_range(0, 15));
      run_op(f, a, d, (f == 2'd1 && d != 4'd0) ? 9 : 1, 0);
    end

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_inverse.md
# alu_inverse

Sequential inverse-operation unit that pairs with the lab 4 accumulator ALU: it undoes add, multiply and shift with subtract, divide and right shift. It takes an 8-bit operand, usually the ALU's registered 8-bit output, and a 4-bit `Data` value, and returns an 8-bit result and a 4-bit remainder. Subtract, shift and hold complete in one cycle. Divide is an 8-iteration restoring divider with a Start/Done handshake.

## Interface
- No parameters; all widths are fixed (8-bit operand/result, 4-bit data/remainder).
- `Clock`  in  1  single rising-edge clock.
- `Reset_b`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request; sampled only in IDLE.
- `Function`  in  2  0 = subtract, 1 = divide, 2 = logical right shift, 3 = hold.
- `Operand`  in  8  left operand (dividend / minuend / shift source).
- `Data`  in  4  right operand (divisor / subtrahend / shift amount).
- `Result`  out  8  registered result.
- `Remainder`  out  4  registered division remainder; 0 for all other functions.
- `Busy`  out  1  high whenever state is not IDLE.
- `Done`  out  1  one-cycle pulse when Result/Remainder are updated.
- `DivByZero`  out  1  registered flag; set on a divide with `Data` == 0.

## Operation
- States: IDLE, DIV, DONE.
- IDLE, Start = 0: stay in IDLE; outputs hold.
- IDLE, Start = 1: latch `Operand`, `Data` and `Function`; clear `DivByZero`; then act by Function:
  - 0: Result = Operand − {4'b0, Data}, modulo 256 (wraps, no borrow output); Remainder = 0; go to DONE.
  - 2: Result = Operand >> Data, logical; Data ≥ 8 gives 0; Remainder = 0; go to DONE.
  - 3: Result unchanged; Remainder = 0; go to DONE.
  - 1 with Data = 0: Result = 8'hFF; Remainder = 4'hF; DivByZero = 1; go to DONE with no iterations.
  - 1 with Data ≠ 0: load the quotient shift register with Operand, the 5-bit partial remainder with 0, and the iteration count with 8; go to DIV.
- DIV, each cycle (MSB first):
  - p = {rem[3:0], q[7]}; q <<= 1.
  - If p ≥ {1'b0, divisor}: rem = p − divisor and q[0] = 1; otherwise rem = p.
  - Decrement the count.
  - On the 8th iteration, write Result = q and Remainder = rem[3:0], then go to DONE.
- DONE: Done = 1 for exactly this one cycle; go to IDLE unconditionally.
- Start while Busy (DIV or DONE) is ignored; no queuing.
- Latched operands are used throughout; input changes during DIV have no effect.
- Result, Remainder and DivByZero hold their values until the next accepted Start.

## Timing
- Reset (`Reset_b` low, asynchronous): state = IDLE and every output is 0 (Result = 0, Remainder = 0, Busy = 0, Done = 0, DivByZero = 0).
  - Reset asserted mid-divide aborts it: no Done, outputs zeroed.
  - Operation resumes on the first rising edge after `Reset_b` goes high.
- Non-divide (and divide-by-zero): Start sampled at edge N → Result valid and Done = 1 in the cycle after edge N; back in IDLE after edge N+1. Latency 1 cycle; next Start accepted at edge N+2.
- Divide: Start at edge N → iterations on edges N+1 … N+8 → Result valid and Done = 1 after edge N+8; back in IDLE after edge N+9. Busy is high from after edge N through the Done cycle.
- Width rules:
  - Partial remainder is 5 bits; maximum p = 2·14 + 1 = 29, so no overflow.
  - Final remainder is always < divisor ≤ 15, so it fits in 4 bits.
  - Subtraction is 8-bit two's-complement wrap.

## Test plan
- Subtract:
  - Operand = 8'h10, Data = 3, Function = 0, Start pulse → Result = 8'h0D, Remainder = 0, Done one cycle later.
  - Operand = 8'h02, Data = 5 → Result = 8'hFD.
- Divide: Operand = 200, Data = 7, Function = 1 → Busy for 9 cycles; Result = 28 (8'h1C), Remainder = 4; Done exactly after 9 clocks; DivByZero = 0.
- Divide by zero: Operand = 8'h55, Data = 0 → after 1 cycle Result = 8'hFF, Remainder = 4'hF, DivByZero = 1; a following subtract clears DivByZero.
- Shift:
  - Operand = 8'hB4, Data = 2, Function = 2 → Result = 8'h2D.
  - Data = 9 → Result = 8'h00.
  - Function = 3 afterwards → Result stays 8'h00, Done pulses.
- Busy and reset:
  - Start a divide of 255 / 15, then pulse Start with Function = 0 in cycle 3 → ignored; final Result = 17, Remainder = 0.
  - Repeat the divide and drop `Reset_b` in cycle 5 → all outputs 0 immediately, no Done.
  - After release, a new Start works normally.
